// File: rtl/frame_assembly.sv
// frame_assembly: serializes sync + 28-bit payload (+ even parity when FRAME_ASSEMBLY_PARITY_EN is defined) one bit per clock
// Reset rst is asynchronous and active-low.
module frame_assembly #(
   parameter int DATA_W = 28,
   parameter int SYNC_W = 8,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hD5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              vin,
   output logic              dout,
   output logic              ready
);
`ifdef FRAME_ASSEMBLY_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int N  = SYNC_W + DATA_W + P;
   localparam int CW = $clog2(N);
   typedef enum logic {IDLE, SEND} state_t;
   state_t          state, state_n;
   logic [N-1:0]    sr, sr_n, frame;
   logic [CW-1:0]   cnt, cnt_n;
   logic            accept;
`ifdef FRAME_ASSEMBLY_PARITY_EN
   assign frame = {SYNC_PATTERN, din, ^din};
`else
   assign frame = {SYNC_PATTERN, din};
`endif
   assign ready  = (state == IDLE) || (state == SEND && cnt == '0);
   assign accept = vin && ready;
   // the shift register drains to zero after the last bit, which gives the idle level
   assign dout   = sr[N-1];
   always_comb begin
      state_n = accept ? SEND : (state == SEND && cnt == '0) ? IDLE : state;
      cnt_n   = accept ? CW'(N-1) : (cnt != '0) ? cnt - CW'(1) : cnt;
      sr_n    = accept ? frame : {sr[N-2:0], 1'b0};
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         sr    <= sr_n;
         cnt   <= cnt_n;
      end
   end
endmodule

// File: tb/tb_frame_assembly.sv
// tb_frame_assembly: randomized scoreboard bench for frame_assembly against a bit-queue frame model
module tb_frame_assembly;
`ifdef FRAME_ASSEMBLY_PARITY_EN
   localparam bit PAR = 1;
`else
   localparam bit PAR = 0;
`endif
   localparam logic [7:0] SYNC = 8'hD5;
   logic        clk = 0, rst = 0, vin = 0, dout, ready;
   logic [27:0] din = '0;
   int          checks = 0, failures = 0;
   bit          q[$];
   frame_assembly dut (.clk(clk), .rst(rst), .din(din), .vin(vin), .dout(dout), .ready(ready));
   always #5 clk = ~clk;
   // model: a frame is just the list of bits the line must carry, in order
   task automatic push_frame(input logic [27:0] d);
      for (int i = 7; i >= 0; i--) q.push_back(SYNC[i]);
      for (int i = 27; i >= 0; i--) q.push_back(d[i]);
      if (PAR) q.push_back($countones(d) % 2 == 1);
   endtask
   always @(negedge clk) begin : monitor
      bit e;
      e = (q.size() > 0) ? q.pop_front() : 1'b0;
      checks++;
      if (dout !== e) begin
         failures++;
         $display("FAIL dout t=%0t got=%b exp=%b", $time, dout, e);
      end
      checks++;
      if (ready !== (q.size() == 0)) begin
         failures++;
         $display("FAIL ready t=%0t got=%b exp=%b", $time, ready, q.size() == 0);
      end
   end
   task automatic cycle(input bit v, input logic [27:0] d, output bit acc);
      @(negedge clk);
      #1;
      vin = v;
      din = d;
      acc = v && rst && q.size() == 0;
      if (acc) push_frame(d);
   endtask
   task automatic send(input logic [27:0] d);
      bit acc = 0;
      for (int i = 0; i < 100 && !acc; i++) cycle(1, d, acc);
      checks++;
      if (!acc) begin
         failures++;
         $display("FAIL send_timeout word=%h got=no_accept exp=accept", d);
      end
   endtask
   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cycle(0, $urandom, acc);
   endtask
   initial begin
      bit acc;
      repeat (2) @(negedge clk);
      #1 rst = 1;
      idle(3);
      send(28'h0000001); idle(45);
      send(28'hFFFFFFE); idle(45);
      send(28'h94BA8F8); idle(45);
      send(28'h0000001); send(28'hFFFFFFE); idle(45);
      send(28'h0000001);
      idle(10);
      cycle(1, 28'hABCDEF0, acc);
      idle(40);
      send(28'h94BA8F8);
      idle(12);
      @(negedge clk);
      #1 rst = 0;
      q.delete();
      #1;
      checks++;
      if (dout !== 1'b0 || ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_abort got=%b%b exp=01", dout, ready);
      end
      repeat (2) @(negedge clk);
      #1 rst = 1;
      idle(45);
      for (int k = 0; k < 20; k++) begin
         send($urandom);
         for (int j = 0; j < 6; j++) cycle($urandom_range(0, 1), $urandom, acc);
         idle($urandom_range(0, 40));
      end
      vin = 0;
      idle(45);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
